core_pipe_fetch_buffer_hw: RTL
==============================

Name: core_pipe_fetch_buffer_hw

Overview:
- Parametrised halfword-granular instruction fetch buffer between the fetch bus interface and the decode stage.
- Accepts up to IN_HW halfwords per cycle through a valid/ready handshake. A skip count drops leading halfwords on misaligned fetch starts.
- Presents the oldest OUT_HW halfwords to decode and drains 0..DRAIN_MAX halfwords per cycle.
- Adds over the previous generation: configurable capacity and widths, backpressure, per-halfword valid mask, and an overrun flag.

Parameters:
- BUF_HW, 8, buffer capacity in 16-bit halfwords; must be at least IN_HW + DRAIN_MAX.
- IN_HW, 4, halfwords per fill beat; fill_data width is 16*IN_HW.
- OUT_HW, 2, halfwords presented on data_out.
- DRAIN_MAX, 2, maximum halfwords drained per cycle; must be no greater than OUT_HW.
- CW, $clog2(BUF_HW+1), width of the depth counters.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  synchronous active-low reset.
- flush  in  1  discard all buffered data.
- fill_valid  in  1  fill beat offered.
- fill_ready  out  1  buffer can accept a full beat.
- fill_data  in  16*IN_HW  fetched halfwords; halfword 0 is the oldest.
- fill_error  in  1  beat carries a fetch error.
- fill_skip  in  $clog2(IN_HW)  number of leading halfwords of the beat to drop.
- drain_count  in  $clog2(DRAIN_MAX+1)  halfwords consumed this cycle.
- data_out  out  16*OUT_HW  oldest halfwords; halfword 0 is the oldest.
- error_out  out  OUT_HW  per-halfword error tag.
- valid_out  out  OUT_HW  per-halfword valid; thermometer code of min(depth, OUT_HW).
- depth  out  CW  current occupancy in halfwords (registered).
- n_depth  out  CW  next-cycle occupancy.
- overrun  out  1  registered pulse: drain_count exceeded depth.

Behaviour:
- Reset (g_resetn low at a clock edge):
  - depth=0, data and error storage=0, overrun=0.
  - Hence valid_out=0, data_out=0, error_out=0, and fill_ready=1.
- fill_ready = (BUF_HW - depth) >= IN_HW.
  - Depends on registered depth only, so there is no combinational path from drain_count or fill_valid.
- Fill accepted: fill_acc = fill_valid && fill_ready && !flush.
  - Halfwords are taken in order, starting at index fill_skip.
  - fill_add = IN_HW - fill_skip.
  - All accepted halfwords get error tag = fill_error.
- Effective drain: eff_drain = min(drain_count, depth).
  - drain_count > depth clamps to depth and sets overrun=1 for exactly the next cycle.
  - No other state is corrupted.
- n_depth:
  - flush: 0.
  - otherwise: depth - eff_drain + (fill_acc ? fill_add : 0).
- Storage update in one cycle:
  - Shift existing contents down by eff_drain halfwords.
  - Insert new halfwords at position depth - eff_drain.
  - Halfwords beyond n_depth read as 0.
- Simultaneous fill and drain are supported in the same cycle.
  - Space is checked against pre-drain depth, so occupancy never exceeds BUF_HW.
- Latency: a halfword accepted in cycle N appears on data_out in cycle N+1 at the earliest, when the buffer was empty or fully drained at N.
- flush:
  - Takes priority over fill and drain.
  - Next cycle: depth=0, storage=0, overrun=0.
  - A fill offered in the flush cycle is dropped; fill_ready is still 1 if depth allowed it, and the upstream side must re-issue.
- Reset mid-operation behaves as flush and also clears overrun.
- fill_valid with fill_ready=0: no state change to the fill path. Upstream holds data stable (standard valid/ready rule).
- fill_skip is ignored when fill_acc=0.
- fill_skip >= IN_HW is illegal; the bench asserts against it.
- Error propagation: error_out[i] = stored tag of halfword i, masked by valid_out[i].
- No state machine beyond occupancy. All arithmetic is unsigned in CW bits; the parameter constraints guarantee no wrap.

Decomposition:
- Shared package core_fetch_pkg: halfword typedef (16-bit), FB_BUF_HW/FB_IN_HW/FB_OUT_HW defaults, and the halfword-plus-error entry struct.
- One natural sub-module, core_fetch_buffer_align: a combinational halfword aligner that shifts a beat by fill_skip and then up by the insert position, producing data and a halfword mask.
- Occupancy, handshake and storage registers stay in the top module.

Test Plan (defaults BUF_HW=8, IN_HW=4, OUT_HW=2, DRAIN_MAX=2):
- Reset then fill beat 0x4444_3333_2222_1111, skip 0, error 0 -> next cycle depth=4, data_out=0x2222_1111, valid_out=2'b11, fill_ready=1.
- Fill twice with no drain -> depth=8, fill_ready=0; a third fill_valid held -> ignored until a drain of 2 makes depth=6, then still not ready; after a second drain (depth=4) it is accepted -> depth=8.
- depth=1, fill beat skip=3 with error=1, drain 1 -> depth=1, data_out[15:0]=beat halfword 3, error_out=2'b01, valid_out=2'b01.
- depth=3, drain 2 and fill 4 in the same cycle -> depth=5, data_out=old halfwords 2 then new 0.
- depth=1, drain_count=2 -> depth=0, overrun=1 for one cycle, then 0.
- depth=6, flush with fill_valid=1 -> depth=0, valid_out=0, overrun=0; the fill is not stored.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// Shared types for the halfword fetch buffer.
// Halfword, entry and default geometry definitions.
package core_fetch_pkg;

    typedef logic [15:0] halfword_t;

    localparam int FB_BUF_HW = 8;
    localparam int FB_IN_HW  = 4;
    localparam int FB_OUT_HW = 2;

    typedef struct packed {
        halfword_t data;
        logic      err;
    } fb_entry_t;

endpackage

// File: rtl/core_fetch_buffer_align.sv
// Combinational halfword aligner for fill beats.
// Drops skip leading halfwords, then places the rest at pos.
module core_fetch_buffer_align
    import core_fetch_pkg::*;
#(
    parameter int BUF_HW = FB_BUF_HW,
    parameter int IN_HW  = FB_IN_HW,
    parameter int SW     = $clog2(FB_IN_HW),
    parameter int PW     = $clog2(FB_BUF_HW + 1)
) (
    input  logic [16*IN_HW-1:0]  beat,
    input  logic [SW-1:0]        skip,
    input  logic [PW-1:0]        pos,
    input  logic                 en,
    output logic [16*BUF_HW-1:0] data,
    output logic [BUF_HW-1:0]    mask
);

    always_comb begin
        data = '0;
        mask = '0;
        for (int i = 0; i < BUF_HW; i++) begin
            for (int k = 0; k < IN_HW; k++) begin
                if (en && k >= int'(skip) &&
                    i == int'(pos) + k - int'(skip)) begin
                    data[16*i +: 16] = beat[16*k +: 16];
                    mask[i]          = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_pipe_fetch_buffer_hw.sv
// Halfword-granular instruction fetch buffer feeding decode.
// Occupancy, handshake and storage live here; alignment is delegated.
module core_pipe_fetch_buffer_hw
    import core_fetch_pkg::*;
#(
    parameter int BUF_HW    = FB_BUF_HW,
    parameter int IN_HW     = FB_IN_HW,
    parameter int OUT_HW    = FB_OUT_HW,
    parameter int DRAIN_MAX = 2,
    parameter int CW        = $clog2(BUF_HW + 1)
) (
    input  logic                           g_clk,
    input  logic                           g_resetn,
    input  logic                           flush,
    input  logic                           fill_valid,
    output logic                           fill_ready,
    input  logic [16*IN_HW-1:0]            fill_data,
    input  logic                           fill_error,
    input  logic [$clog2(IN_HW)-1:0]       fill_skip,
    input  logic [$clog2(DRAIN_MAX+1)-1:0] drain_count,
    output logic [16*OUT_HW-1:0]           data_out,
    output logic [OUT_HW-1:0]              error_out,
    output logic [OUT_HW-1:0]              valid_out,
    output logic [CW-1:0]                  depth,
    output logic [CW-1:0]                  n_depth,
    output logic                           overrun
);

    localparam int SW = $clog2(IN_HW);
    localparam logic [CW-1:0] BUF_C = CW'(BUF_HW);
    localparam logic [CW-1:0] IN_C  = CW'(IN_HW);

    fb_entry_t buf_q [BUF_HW];
    fb_entry_t buf_d [BUF_HW];

    logic [CW-1:0] depth_q;
    logic [CW-1:0] dc;
    logic [CW-1:0] eff_drain;
    logic [CW-1:0] ins_pos;
    logic [CW-1:0] fill_add;
    logic          fill_acc;
    logic          overrun_q;

    logic [16*BUF_HW-1:0] al_data;
    logic [BUF_HW-1:0]    al_mask;

    // Space is judged on registered depth only, before any drain.
    assign fill_ready = (BUF_C - depth_q) >= IN_C;
    assign fill_acc   = fill_valid && fill_ready && !flush;

    assign dc        = CW'(drain_count);
    assign eff_drain = (dc > depth_q) ? depth_q : dc;
    assign ins_pos   = depth_q - eff_drain;
    assign fill_add  = IN_C - CW'(fill_skip);
    assign n_depth   = flush ? '0 :
                       ins_pos + (fill_acc ? fill_add : '0);

    core_fetch_buffer_align #(
        .BUF_HW (BUF_HW),
        .IN_HW  (IN_HW),
        .SW     (SW),
        .PW     (CW)
    ) u_align (
        .beat (fill_data),
        .skip (fill_skip),
        .pos  (ins_pos),
        .en   (fill_acc),
        .data (al_data),
        .mask (al_mask)
    );

    always_comb begin
        for (int i = 0; i < BUF_HW; i++) begin
            buf_d[i] = '0;
            for (int j = 0; j < BUF_HW; j++) begin
                if (j == i + int'(eff_drain) && CW'(j) < depth_q) begin
                    buf_d[i] = buf_q[j];
                end
            end
            if (al_mask[i]) begin
                buf_d[i] = '{data: al_data[16*i +: 16], err: fill_error};
            end
            if (flush) begin
                buf_d[i] = '0;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            depth_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < BUF_HW; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            depth_q   <= n_depth;
            overrun_q <= !flush && (dc > depth_q);
            for (int i = 0; i < BUF_HW; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        valid_out = '0;
        data_out  = '0;
        error_out = '0;
        for (int i = 0; i < OUT_HW; i++) begin
            valid_out[i]        = CW'(i) < depth_q;
            data_out[16*i +: 16] = buf_q[i].data;
            error_out[i]        = buf_q[i].err & (CW'(i) < depth_q);
        end
    end

    assign depth   = depth_q;
    assign overrun = overrun_q;

endmodule
